// File: rtl/out_pass_pkg.sv
// Shared constants for the output pass block: per-channel mode encodings
// and the configuration chain length helper.
package out_pass_pkg;

    localparam int CFG_W = 2;

    typedef enum logic [1:0] {
        MODE_COMB  = 2'b00,
        MODE_REG   = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_PIPE2 = 2'b11
    } chan_mode_e;

    function automatic int cfg_bits(input int num_ch);
        return num_ch * CFG_W;
    endfunction

endpackage

// File: rtl/out_pass_chan.sv
// One output channel: stage registers S1/S2 and the mode-selected output mux.
module out_pass_chan
    import out_pass_pkg::*;
(
    input  logic       UserCLK,
    input  logic       RST,
    input  logic       d,
    input  logic       en,
    input  chan_mode_e mode,
    output logic       q
);

    logic s1;
    logic s2;

    // Both stages keep clocking in every mode so a mode switch shows defined data.
    always_ff @(posedge UserCLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            if (mode != MODE_HOLD || en) begin
                s1 <= d;
            end
            s2 <= s1;
        end
    end

    always_comb begin
        q = d;
        case (mode)
            MODE_COMB:  q = d;
            MODE_REG:   q = s1;
            MODE_HOLD:  q = s1;
            MODE_PIPE2: q = s2;
            default:    q = d;
        endcase
    end

endmodule

// File: rtl/out_pass_res.sv
// Output pass block: per-channel result drive to external pins, with modes
// loaded over a serial configuration chain and blanking around configuration.
module out_pass_res #(
    parameter int NUM_CH = 4,
    parameter int CFG_W  = out_pass_pkg::CFG_W
) (
    input  logic              UserCLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] RES_I,
    input  logic [NUM_CH-1:0] RES_EN,
    output logic [NUM_CH-1:0] RES_O,
    input  logic              MODE,
    input  logic              CONFin,
    output logic              CONFout
);
    import out_pass_pkg::*;

    localparam int N = cfg_bits(NUM_CH);

    logic [N-1:0]      cfg;
    logic              cfg_settle;
    logic [NUM_CH-1:0] q;

    // cfg_settle is MODE delayed by one edge: it keeps the pins blanked for
    // the cycle after MODE falls so registered channels can refill.
    always_ff @(posedge UserCLK) begin
        if (RST) begin
            cfg        <= '0;
            cfg_settle <= 1'b0;
        end else begin
            if (MODE) begin
                cfg <= {cfg[N-2:0], CONFin};
            end
            cfg_settle <= MODE;
        end
    end

    assign CONFout = cfg[N-1];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        out_pass_chan u_chan (
            .UserCLK (UserCLK),
            .RST     (RST),
            .d       (RES_I[k]),
            .en      (RES_EN[k]),
            .mode    (chan_mode_e'(cfg[CFG_W*k +: CFG_W])),
            .q       (q[k])
        );
    end

    assign RES_O = (MODE || cfg_settle) ? '0 : q;

endmodule

// File: tb/tb_out_pass_res.sv
// Directed bench for out_pass_res: table of per-cycle vectors plus
// hand-written reset-during-shift and chain pass-through sequences.
module tb_out_pass_res;

    logic       UserCLK = 1'b0;
    logic       RST;
    logic [3:0] RES_I;
    logic [3:0] RES_EN;
    logic [3:0] RES_O;
    logic       MODE;
    logic       CONFin;
    logic       CONFout;

    int total = 0;
    int bad   = 0;

    out_pass_res #(.NUM_CH(4), .CFG_W(2)) dut (
        .UserCLK (UserCLK),
        .RST     (RST),
        .RES_I   (RES_I),
        .RES_EN  (RES_EN),
        .RES_O   (RES_O),
        .MODE    (MODE),
        .CONFin  (CONFin),
        .CONFout (CONFout)
    );

    always #5 UserCLK = ~UserCLK;

    typedef struct {
        logic       rst;
        logic       mode;
        logic       ci;
        logic [3:0] res_i;
        logic [3:0] res_en;
        logic [3:0] exp_o;
        logic       exp_co;
    } vec_t;

    vec_t vecs[18];

    // Drive one cycle's inputs, check outputs mid-cycle, then advance one edge.
    task automatic cyc(input logic r, input logic m, input logic ci,
                       input logic [3:0] ri, input logic [3:0] en,
                       input logic [3:0] eo, input logic eco,
                       input string nm, input int idx);
        RST = r; MODE = m; CONFin = ci; RES_I = ri; RES_EN = en;
        #2;
        total++;
        if (RES_O !== eo) begin
            bad++;
            $display("FAIL %s[%0d] RES_O got=%b want=%b", nm, idx, RES_O, eo);
        end
        total++;
        if (CONFout !== eco) begin
            bad++;
            $display("FAIL %s[%0d] CONFout got=%b want=%b", nm, idx, CONFout, eco);
        end
        @(posedge UserCLK);
        #1;
    endtask

    logic [15:0] word;
    logic        exp_co;

    initial begin
        // Post-reset COMB, then config 1,1,1,0,0,1,0,0 -> ch3 PIPE2, ch2 HOLD, ch1 REG, ch0 COMB
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 4'b0000, 4'b1010, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        // settle cycle: blanked, CONFout now shows first bit shifted in
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        // step to 1111: ch0 now, ch1 +1, ch3 +2, ch2 waits for RES_EN
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0011, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1011, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0100, 4'b1011, 1'b1};
        // HOLD keeps 1 while RES_I[2] toggles with RES_EN low
        vecs[14] = '{1'b0, 1'b0, 1'b0, 4'b1011, 4'b0000, 4'b1111, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1110, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b1100, 1'b1};
        // RES_EN on non-HOLD channels is ignored
        vecs[17] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1011, 4'b0100, 1'b1};

        RST = 1'b1; MODE = 1'b0; CONFin = 1'b0; RES_I = '0; RES_EN = '0;
        @(posedge UserCLK);
        @(posedge UserCLK);
        #1;

        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].rst, vecs[i].mode, vecs[i].ci, vecs[i].res_i,
                vecs[i].res_en, vecs[i].exp_o, vecs[i].exp_co, "table", i);
        end

        // Reset lands together with MODE=1 mid-shift: cfg cleared, not shifted,
        // and no settle blanking afterwards.
        cyc(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, "rst_mid", 0);
        cyc(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, "rst_mid", 1);
        cyc(1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, "rst_mid", 2);
        cyc(1'b0, 1'b0, 1'b0, 4'b0110, 4'b0000, 4'b0110, 1'b0, "rst_mid", 3);
        cyc(1'b0, 1'b0, 1'b0, 4'b1001, 4'b1111, 4'b1001, 1'b0, "rst_mid", 4);

        // Chain pass-through: first 8 bits of 0xA5C3 reappear 8 edges later.
        word = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            exp_co = (i >= 8) ? word[15 - (i - 8)] : 1'b0;
            cyc(1'b0, 1'b1, word[15 - i], 4'b0000, 4'b0000, 4'b0000, exp_co, "chain", i);
        end
        // cfg now 0xC3: ch3/ch0 PIPE2, ch2/ch1 COMB
        cyc(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, "chain_post", 0);
        cyc(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0110, 1'b1, "chain_post", 1);
        cyc(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b1, "chain_post", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/out_pass_res.md
Name: out_pass_res

Overview:
- Output-direction pass block: carries NUM_CH fabric result signals out of the tile to EXTERNAL pins.
- It is the counterpart of the input pass block, which brings external operands into the fabric.
- Each channel can be set to one of four output modes: combinational, registered, registered with enable-hold, or two-stage pipelined.
- The mode is loaded over a serial configuration chain. The block sits at the tile edge, between the switch matrix outputs and the top-level pins.

Parameters:
- NUM_CH, 4, number of result channels.
- CFG_W, 2, configuration bits per channel (fixed at 2; parameter exists for the package constant).

Ports:
- UserCLK  input  1  single clock for datapath and configuration chain.
- RST  input  1  synchronous, active-high reset.
- RES_I  input  NUM_CH  fabric result bits, one per channel (from switch matrix).
- RES_EN  input  NUM_CH  per-channel capture enable (from switch matrix); used only in mode HOLD.
- RES_O  output  NUM_CH  EXTERNAL pin drive, one per channel.
- MODE  input  1  1 = configuration, 0 = action.
- CONFin  input  1  serial configuration data in.
- CONFout  output  1  serial configuration data out (chain continues to the next block).

Behaviour:
- Clocking and reset:
  - One clock (UserCLK); reset is synchronous and active-high (RST). All state updates on the rising edge of UserCLK.
  - RST=1 at an edge clears: config register (all zero, so all channels COMB), stage-1 regs S1, stage-2 regs S2, and the MODE-delay flag. RST takes priority over MODE and over data.
  - After reset: RES_O = RES_I (COMB), CONFout = 0.
- Configuration chain:
  - Shift register CFG of NUM_CH*CFG_W bits (8 at default).
  - While MODE=1, each edge does CFG <= {CFG[N-2:0], CONFin}.
  - CONFout = CFG[N-1] (registered, MSB-first out).
  - Channel k mode = CFG[2k+1:2k]. The first bit shifted in ends in the MSB, i.e. channel NUM_CH-1 bit 1.
  - While MODE=0, CFG holds.
- Channel modes (per channel k):
  - 00 COMB: RES_O[k] = RES_I[k]; latency 0.
  - 01 REG: S1[k] <= RES_I[k] every edge; RES_O[k] = S1[k]; latency 1.
  - 10 HOLD: S1[k] <= RES_I[k] only when RES_EN[k]=1, otherwise it holds; RES_O[k] = S1[k]; latency 1 from an enabled edge.
  - 11 PIPE2: S1[k] <= RES_I[k]; S2[k] <= S1[k]; RES_O[k] = S2[k]; latency 2.
  - S1 and S2 clock in every mode except the HOLD rule on S1, so switching modes exposes stale but defined data.
- Safe output during configuration:
  - While MODE=1, RES_O = all 0, regardless of channel mode.
  - On the first edge where MODE returns to 0, a one-cycle flag cfg_settle is set. While it is set, RES_O stays 0 for one more cycle.
  - This lets registered channels refill. S1 and S2 keep updating during MODE=1 and during settle.
- Boundary conditions:
  - RST and MODE=1 at the same edge: reset wins; CFG is cleared, not shifted.
  - Mode change mid-stream takes effect at the next edge after the final configuration shift.
  - RES_EN in non-HOLD modes is ignored.
  - HOLD with RES_EN never asserted after reset outputs 0.

Decomposition:
- Shared package out_pass_pkg:
  - localparams CFG_W=2.
  - Mode encodings MODE_COMB=2'b00, MODE_REG=2'b01, MODE_HOLD=2'b10, MODE_PIPE2=2'b11.
  - Function cfg_bits(NUM_CH) returning the chain length.
- One sub-module, out_pass_chan: per-channel S1/S2 registers and output mux. Inputs: UserCLK, RST, d, en, mode[1:0]. Output: q. Generated NUM_CH times.
- The top level holds the CFG shift register, the cfg_settle flag and the output blanking.

Test Plan:
- Reset then MODE=0, drive RES_I=4'b1010 -> RES_O=4'b1010 in the same cycle (all COMB); CONFout=0.
- Shift CONFin stream 1,1,1,0,0,1,0,0 with MODE=1 (ch3=PIPE2, ch2=HOLD, ch1=REG, ch0=COMB); RES_O=0 throughout and for 1 cycle after MODE falls; CONFout shows the shifted bits after 8 edges.
- After config, step RES_I=4'b1111 at edge t -> RES_O[0]=1 at t, RES_O[1]=1 at t+1, RES_O[3]=1 at t+2; RES_O[2] stays 0 until RES_EN[2]=1.
- HOLD channel: RES_EN[2]=1 with RES_I[2]=1 for one edge, then RES_EN[2]=0 and RES_I[2] toggles -> RES_O[2] stays 1.
- Assert RST for one edge during mid-stream shift with MODE=1 -> CFG=0, S1/S2=0, RES_O follows RES_I combinationally on the next cycle after MODE=0.
- Chain pass-through: shift 16 bits 0xA5C3 -> CONFout emits the first 8 bits (0xA5) delayed by exactly 8 edges.
